// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit.
//   Size encodings, FSM state encodings, default timeout and the
//   registered command payload captured at start.
package load_store_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // cpu_size encodings
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Command latched in IDLE and held for the whole access
  typedef struct packed {
    logic              we;
    logic              uns;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } lsu_cmd_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for data-memory accesses.
//   size, offset, is_unsigned : access shape (offset = addr[1:0])
//   wdata  : right-justified store data   -> wdata_c : lane-replicated
//   rdata  : raw memory word              -> rdata_c : extracted, extended
//   be_c   : byte enables, misalign_c : illegal size or misaligned
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              misalign_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Half lane uses offset[1] only; odd offsets are flagged misaligned anyway
  assign byte_lane = rdata[{offset, 3'b000} +: 8];
  assign half_lane = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    be_c       = 4'b1111;
    wdata_c    = wdata;
    rdata_c    = rdata;
    misalign_c = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be_c    = 4'b0001 << offset;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      end
      SIZE_HALF: begin
        be_c       = 4'b0011 << offset;
        wdata_c    = {2{wdata[15:0]}};
        rdata_c    = {{16{~is_unsigned & half_lane[15]}}, half_lane};
        misalign_c = offset[0];
      end
      SIZE_WORD: misalign_c = |offset;
      default:   misalign_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per command over a req/ack link.
//   cpu_*  : command in, stall (cpu_busy, combinational), done/fault/rdata out
//   mem_*  : word-aligned byte-enabled request, ack and read data
// Faults (misaligned, illegal size, ack timeout) complete with cpu_fault.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_start,
  input  logic              cpu_write,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  lsu_cmd_t          cmd_q, cmd_d;
  logic [DATA_W-1:0] rdata_d;
  logic              done_d, fault_d, req_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [BE_W-1:0]   be_d;
  logic [DATA_W-1:0] wdata_d;

  logic [1:0]        al_size, al_offset;
  logic              al_uns;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_c, rdata_c;
  logic              misalign_c;

  // Aligner sees the live command in IDLE and the latched one afterwards
  assign al_size   = (state_q == ST_IDLE) ? cpu_size      : cmd_q.size;
  assign al_offset = (state_q == ST_IDLE) ? cpu_addr[1:0] : cmd_q.addr[1:0];
  assign al_uns    = (state_q == ST_IDLE) ? cpu_unsigned  : cmd_q.uns;

  lsu_align u_align (
    .size        (al_size),
    .offset      (al_offset),
    .is_unsigned (al_uns),
    .wdata       (cpu_wdata),
    .rdata       (mem_rdata),
    .be_c        (be_c),
    .wdata_c     (wdata_c),
    .rdata_c     (rdata_c),
    .misalign_c  (misalign_c)
  );

  // Stall in the start cycle and for the whole request phase
  assign cpu_busy = ((state_q == ST_IDLE) && cpu_start) || (state_q == ST_REQ);

  // Next state, command capture, timeout count and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rdata_d = cpu_rdata;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_start) begin
          cmd_d.we    = cpu_write;
          cmd_d.uns   = cpu_unsigned;
          cmd_d.size  = cpu_size;
          cmd_d.addr  = cpu_addr;
          cmd_d.be    = be_c;
          cmd_d.wdata = wdata_c;
          cnt_d       = '0;
          if (misalign_c) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Ack takes priority over an expiring timeout
        if (mem_ack) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
          if (!cmd_q.we) rdata_d = rdata_c;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_d   = (state_d == ST_REQ);
    we_d    = req_d & cmd_d.we;
    addr_d  = req_d ? {cmd_d.addr[ADDR_W-1:2], 2'b00} : '0;
    be_d    = req_d ? cmd_d.be : '0;
    wdata_d = req_d ? cmd_d.wdata : '0;
  end

  // State and output registers; reset drops any request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      cpu_done  <= 1'b0;
      cpu_fault <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      cpu_done  <= done_d;
      cpu_fault <= fault_d;
      cpu_rdata <= rdata_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_be    <= be_d;
      mem_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses compared against an arithmetic reference model.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_start, cpu_write, cpu_unsigned;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_busy, cpu_done, cpu_fault;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_start    (cpu_start),
    .cpu_write    (cpu_write),
    .cpu_size     (cpu_size),
    .cpu_unsigned (cpu_unsigned),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_busy     (cpu_busy),
    .cpu_done     (cpu_done),
    .cpu_rdata    (cpu_rdata),
    .cpu_fault    (cpu_fault),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: access width in bytes, 0 for the illegal size
  function automatic int unsigned nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input int unsigned nb, input logic [1:0] off);
    int unsigned m;
    if (nb == 4) return 4'hF;
    m = ((32'd1 << nb) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int unsigned nb, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input int unsigned nb, input logic uns,
                                             input logic [1:0] off, input logic [31:0] rd);
    longint v, full;
    if (nb == 4) return rd;
    v    = longint'(rd >> (8 * off));
    full = longint'(1) << (8 * nb);
    v    = v % full;
    if (!uns && v >= full / 2) v = v - full;
    return v[31:0];
  endfunction

  // One complete access: wait_n = memory wait cycles before ack (>= TO never acks)
  task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int unsigned wait_n, input logic [31:0] rd);
    int unsigned nb, n_cyc;
    logic        bad, acked;
    nb    = nbytes(sz);
    bad   = (nb == 0) || ((addr % nb) != 0);
    acked = (wait_n < TO);
    n_cyc = acked ? wait_n + 1 : TO;
    @(negedge clk);
    check("idle_done", 32'(cpu_done), 32'd0);
    cpu_start = 1'b1; cpu_write = wr; cpu_size = sz; cpu_unsigned = uns;
    cpu_addr = addr; cpu_wdata = wd;
    #1;
    check("busy_start", 32'(cpu_busy), 32'd1);
    check("req_start", 32'(mem_req), 32'd0);
    @(negedge clk);
    cpu_start = 1'b0; cpu_write = 1'($urandom); cpu_size = 2'($urandom);
    cpu_addr = $urandom; cpu_wdata = $urandom;
    if (bad) begin
      check("fault_done", 32'(cpu_done), 32'd1);
      check("fault_flag", 32'(cpu_fault), 32'd1);
      check("fault_noreq", 32'(mem_req), 32'd0);
      check("fault_busy", 32'(cpu_busy), 32'd0);
      check("fault_rdata", cpu_rdata, exp_rdata);
    end else begin
      for (int unsigned k = 0; k < n_cyc; k++) begin
        if (k > 0) @(negedge clk);
        check("req", 32'(mem_req), 32'd1);
        check("we", 32'(mem_we), 32'(wr));
        check("addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("be", 32'(mem_be), 32'(model_be(nb, addr[1:0])));
        if (wr) check("wdata", mem_wdata, model_wdata(nb, wd));
        check("busy_req", 32'(cpu_busy), 32'd1);
        check("early_done", 32'(cpu_done), 32'd0);
        mem_ack   = acked && (k == wait_n);
        mem_rdata = mem_ack ? rd : $urandom;
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (acked && !wr) exp_rdata = model_load(nb, uns, addr[1:0], rd);
      check("done", 32'(cpu_done), 32'd1);
      check("fault", 32'(cpu_fault), 32'(!acked));
      check("rdata", cpu_rdata, exp_rdata);
      check("resp_req", 32'(mem_req), 32'd0);
      check("resp_busy", 32'(cpu_busy), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    rst_n = 1'b0; cpu_start = 1'b0; cpu_write = 1'b0; cpu_size = 2'b00;
    cpu_unsigned = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    exp_rdata = '0;
    #3;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    access(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 3, 32'h0);
    access(1'b0, 2'b00, 1'b0, 32'h1001_0003, 32'h0, 0, 32'h80FF_0000);
    access(1'b0, 2'b00, 1'b1, 32'h1001_0003, 32'h0, 0, 32'h80FF_0000);
    access(1'b1, 2'b01, 1'b0, 32'h1001_0002, 32'h0000_ABCD, 1, 32'h0);
    access(1'b0, 2'b01, 1'b0, 32'h1001_0002, 32'h0, 2, 32'h9234_0000);
    access(1'b0, 2'b10, 1'b0, 32'h1001_0006, 32'h0, 0, 32'h0);
    access(1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0, 0, 32'h0);
    access(1'b0, 2'b01, 1'b0, 32'h1001_0001, 32'h0, 0, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, 2 * TO, 32'h1234_5678);
    access(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, TO - 1, 32'h1234_5678);

    // Reset in the middle of a request
    @(negedge clk);
    cpu_start = 1'b1; cpu_write = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h1001_0010;
    @(negedge clk); cpu_start = 1'b0;
    @(negedge clk);
    check("mid_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_drop", 32'(mem_req), 32'd0);
    check("async_busy", 32'(cpu_busy), 32'd0);
    check("async_rdata", cpu_rdata, 32'd0);
    exp_rdata = '0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_done", 32'(cpu_done), 32'd0);
      check("stray_req", 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;
    access(1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0, 1, 32'h0BAD_CAFE);

    // Randomized accesses
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      access(1'($urandom), (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
             1'($urandom), a, $urandom, $urandom_range(0, TO + 1), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Processor-side initiator for data-memory accesses. Takes one load/store command from the datapath (address from the ALU, store data from `rt`, size/sign from control), issues a single word-aligned, byte-enabled request to data memory over a req/ack handshake, and returns aligned, extended load data. It stalls the PC while the access is outstanding and flags misaligned, illegal-size or timed-out accesses.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles in REQ without `mem_ack` before the access is aborted with a fault; must be ≥1.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_start`  in  1  command valid; sampled only in IDLE.
- `cpu_write`  in  1  1 = store, 0 = load.
- `cpu_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `cpu_unsigned`  in  1  zero-extend loads (lbu/lhu); ignored for words and stores.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data, right-justified.
- `cpu_busy`  out  1  stall request to PC/datapath.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  32  load result, valid with `cpu_done`, held until next `cpu_done`.
- `cpu_fault`  out  1  valid with `cpu_done`; misaligned, illegal size or timeout.
- `mem_req`  out  1  request valid.
- `mem_we`  out  1  write request.
- `mem_addr`  out  32  word address, bits [1:0] always 0.
- `mem_be`  out  4  byte enables; lane n = bits [8n+7:8n] (little-endian).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory accepts/completes request this cycle.
- `mem_rdata`  in  32  read word, valid with `mem_ack` on reads.

## Operation
- States: IDLE, REQ, RESP.
- IDLE + `cpu_start`: register command. If size 11, or half with `addr[0]`=1, or word with `addr[1:0]`≠0, go to RESP with fault; no memory request. Otherwise go to REQ.
- REQ: `mem_req`=1; `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` stable for the whole state. On `mem_ack`: capture `mem_rdata` if read, go to RESP. On timeout count reaching `TIMEOUT_CYCLES` without ack: go to RESP with fault, `cpu_rdata` unchanged.
- RESP: `cpu_done`=1 for exactly one cycle, then IDLE.
- Byte enables: byte `4'b0001<<addr[1:0]`; half `4'b0011<<addr[1:0]`; word `4'b1111` (also driven on reads).
- Store data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word unchanged.
- Load data: extract addressed lane(s); sign-extend unless `cpu_unsigned`.
- `cpu_start` outside IDLE is ignored; no queueing.

## Timing
- Reset (async, any state): state IDLE; all outputs 0, including `cpu_rdata`; any in-flight request is dropped immediately and its ack is ignored.
- `cpu_busy` = (IDLE and `cpu_start`) or REQ; combinational, so the PC stalls in the start cycle. Low in RESP, so the PC advances at the end of the done cycle.
- Latency: start sampled at edge 0; `mem_req` high from cycle 1; ack in cycle 1 gives `cpu_done` in cycle 2. Total is 2 + (memory wait cycles).
- Fault path: `cpu_done`+`cpu_fault` in cycle 1; `mem_req` never rises.
- Ack in the same cycle the timeout count expires: ack wins, no fault.
- `mem_*` outputs are 0 when not in REQ.

## Structure
- Size encodings, ALU-independent state encodings, and `TIMEOUT` default go in `mips.h` with the existing shared constants.
- Sub-module `lsu_align`: purely combinational; computes byte enables, store replication, load extraction/extension and misalignment from size, `addr[1:0]` and unsigned flag. FSM, timeout counter and registers stay in `load_store_unit`.

## Test plan
- Word store, addr 0x10010004, data 0xDEADBEEF, ack after 3 wait cycles: `mem_addr`=0x10010004, `mem_be`=1111, `mem_we`=1 held stable; `cpu_done` in cycle 5; busy high cycles 0–4.
- `lb` addr 0x10010003, mem returns 0x80FF_0000 with immediate ack: `mem_be`=1000, `cpu_rdata`=0xFFFFFF80; repeat with `cpu_unsigned`=1 gives 0x00000080.
- `sh` addr 0x10010002, data 0x0000ABCD: `mem_wdata`=0xABCDABCD, `mem_be`=1100.
- `lw` addr 0x10010006: `cpu_done`+`cpu_fault` in cycle 1, `mem_req` never asserted; size 11 behaves the same.
- Never ack, `TIMEOUT_CYCLES`=4: fault with done after 4 REQ cycles; `cpu_rdata` retains the prior value. A second case acks exactly on cycle 4 and completes with no fault.
- Assert `rst_n`=0 mid-REQ: `mem_req` drops without waiting for a clock edge; a later stray ack causes no done; a new `cpu_start` after reset completes normally.
